// File: rtl/bus_to_axi_lite_pipelined_if.sv
// rtl/bus_to_axi_lite_pipelined_if.sv - MemoryBus interface with word-indexed address and ID tagging
interface MemoryBus #(
    parameter int ADDR_W = 30,
    parameter int DATA_W = 24,
    parameter int ID_W   = 8
);
    logic              msValid;
    logic              msWrite;
    logic [ADDR_W-1:0] msAddress;
    logic [DATA_W-1:0] msData;
    logic [ID_W-1:0]   msID;
    logic              msTaken;
    logic              smValid;
    logic [DATA_W-1:0] smData;
    logic [ID_W-1:0]   smID;
    logic              smTaken;

    modport Slave (
        input  msValid, msWrite, msAddress, msData, msID, smTaken,
        output msTaken, smValid, smData, smID
    );

    modport Master (
        output msValid, msWrite, msAddress, msData, msID, smTaken,
        input  msTaken, smValid, smData, smID
    );
endinterface

// File: rtl/bus_to_axi_lite_pipelined.sv
// rtl/bus_to_axi_lite_pipelined.sv - pipelined MemoryBus slave to AXI4-Lite master bridge; AXIL_ERR_COUNT_EN enables rresp/bresp error counters
module bus_to_axi_lite_pipelined #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int BUS_DATA_W = 24,
    parameter int ID_W       = 8,
    parameter int MAX_READS  = 4,
    parameter int MAX_WRITES = 4
) (
    input  logic                clock,
    input  logic                reset,
    MemoryBus.Slave             bus,
    output logic                arvalid,
    input  logic                arready,
    output logic [ADDR_W-1:0]   araddr,
    output logic [2:0]          arprot,
    output logic                awvalid,
    input  logic                awready,
    output logic [ADDR_W-1:0]   awaddr,
    output logic [2:0]          awprot,
    output logic                wvalid,
    input  logic                wready,
    output logic [DATA_W-1:0]   wdata,
    output logic [DATA_W/8-1:0] wstrb,
    input  logic                bvalid,
    output logic                bready,
    input  logic [1:0]          bresp,
    input  logic                rvalid,
    output logic                rready,
    input  logic [DATA_W-1:0]   rdata,
    input  logic [1:0]          rresp,
    output logic [15:0]         rd_err_count,
    output logic [15:0]         wr_err_count
);
    localparam int PW = $clog2(MAX_READS) + 1;
    localparam int CW = $clog2(MAX_WRITES + 1);

    logic [ID_W-1:0]   id_mem [MAX_READS];
    logic [PW-1:0]     wr_ptr, rd_ptr, fifo_count;
    logic              fifo_empty, fifo_full, rd_pop;
    logic              rd_accept, wr_accept, aw_free, w_free, wr_room, b_dec;
    logic [CW-1:0]     wcount;
    logic [ADDR_W-1:0] byte_addr;

    assign byte_addr = {bus.msAddress[ADDR_W-3:0], 2'b00};
    assign arprot    = 3'b000;
    assign awprot    = 3'b000;
    assign wstrb     = '1;
    assign bready    = 1'b1;

    // Full is judged on post-pop occupancy so a push can ride alongside a pop.
    assign fifo_count = wr_ptr - rd_ptr;
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign rd_pop     = rvalid & rready;
    assign fifo_full  = (fifo_count == PW'(MAX_READS)) & !rd_pop;

    assign rready       = bus.smTaken & !fifo_empty;
    assign bus.smValid  = rvalid & !fifo_empty;
    assign bus.smID     = id_mem[rd_ptr[PW-2:0]];
    assign bus.smData   = rdata[BUS_DATA_W-1:0];

    assign aw_free   = !awvalid | awready;
    assign w_free    = !wvalid | wready;
    assign wr_room   = (wcount < CW'(MAX_WRITES)) | bvalid;
    assign rd_accept = bus.msValid & !bus.msWrite & !fifo_full & (!arvalid | arready);
    assign wr_accept = bus.msValid & bus.msWrite & aw_free & w_free & wr_room;
    assign bus.msTaken = rd_accept | wr_accept;
    assign b_dec     = bvalid & (wcount != '0);

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            arvalid <= 1'b0;
            araddr  <= '0;
        end else begin
            if (rd_accept) begin
                id_mem[wr_ptr[PW-2:0]] <= bus.msID;
                wr_ptr  <= wr_ptr + 1'b1;
                arvalid <= 1'b1;
                araddr  <= byte_addr;
            end else if (arready) begin
                arvalid <= 1'b0;
            end
            if (rd_pop)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            awvalid <= 1'b0;
            wvalid  <= 1'b0;
            awaddr  <= '0;
            wdata   <= '0;
            wcount  <= '0;
        end else begin
            if (wr_accept) begin
                awvalid <= 1'b1;
                wvalid  <= 1'b1;
                awaddr  <= byte_addr;
                wdata   <= DATA_W'(bus.msData);
            end else begin
                if (awready) awvalid <= 1'b0;
                if (wready)  wvalid  <= 1'b0;
            end
            case ({wr_accept, b_dec})
                2'b10:   wcount <= wcount + 1'b1;
                2'b01:   wcount <= wcount - 1'b1;
                default: wcount <= wcount;
            endcase
        end
    end

`ifdef AXIL_ERR_COUNT_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_err_count <= '0;
            wr_err_count <= '0;
        end else begin
            if (rd_pop && rresp != 2'b00 && rd_err_count != 16'hFFFF)
                rd_err_count <= rd_err_count + 1'b1;
            if (bvalid && bresp != 2'b00 && wr_err_count != 16'hFFFF)
                wr_err_count <= wr_err_count + 1'b1;
        end
    end
`else
    assign rd_err_count = '0;
    assign wr_err_count = '0;
`endif

    logic unused_ok;
    assign unused_ok = ^{rdata, rresp, bresp};

    // Responses with nothing outstanding indicate a misbehaving AXI slave.
    always_ff @(posedge clock) begin
        if (!reset) begin
            assert (!(rvalid && fifo_empty));
            assert (!(bvalid && wcount == '0));
        end
    end
endmodule

// File: tb/tb_bus_to_axi_lite_pipelined.sv
// tb/tb_bus_to_axi_lite_pipelined.sv - directed self-checking bench for bus_to_axi_lite_pipelined
module tb_bus_to_axi_lite_pipelined;
    logic        clock = 1'b0;
    logic        reset;
    logic        arready, awready, wready, bvalid, rvalid;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;
    logic        arvalid, awvalid, wvalid, bready, rready;
    logic [31:0] araddr, awaddr, wdata;
    logic [2:0]  arprot, awprot;
    logic [3:0]  wstrb;
    logic [15:0] rd_err_count, wr_err_count;
    int tests = 0;
    int failed = 0;

    MemoryBus #(.ADDR_W(30), .DATA_W(24), .ID_W(8)) bus ();

    bus_to_axi_lite_pipelined dut (
        .clock(clock), .reset(reset), .bus(bus),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arprot(arprot),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awprot(awprot),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
        .bvalid(bvalid), .bready(bready), .bresp(bresp),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
        .rd_err_count(rd_err_count), .wr_err_count(wr_err_count)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic bus_idle();
        bus.msValid = 0; bus.msWrite = 0; bus.msAddress = '0; bus.msData = '0;
        bus.msID = '0; bus.smTaken = 0;
    endtask

    task automatic test_reset();
        bus_idle();
        arready = 0; awready = 0; wready = 0; bvalid = 0; rvalid = 0;
        bresp = 0; rresp = 0; rdata = 0;
        reset = 1;
        step(); step();
        reset = 0;
        #1;
        tests++;
        if ({arvalid, awvalid, wvalid, bus.smValid} !== 4'b0000) begin
            failed++; $display("FAIL reset_valids: got %b exp 0000", {arvalid, awvalid, wvalid, bus.smValid});
        end
        tests++;
        if ({rd_err_count, wr_err_count, bready, wstrb, arprot, awprot} !== {32'h0, 1'b1, 4'hF, 6'h0}) begin
            failed++; $display("FAIL reset_consts: errs %h/%h bready %b wstrb %h", rd_err_count, wr_err_count, bready, wstrb);
        end
    endtask

    task automatic test_single_read();
        arready = 1;
        bus.msValid = 1; bus.msWrite = 0; bus.msAddress = 30'h10; bus.msID = 8'h2A;
        #1;
        tests++;
        if (bus.msTaken !== 1'b1) begin failed++; $display("FAIL read_accept: got %b exp 1", bus.msTaken); end
        step();
        bus.msValid = 0;
        tests++;
        if (arvalid !== 1'b1 || araddr !== 32'h40) begin
            failed++; $display("FAIL read_ar: arvalid %b araddr %h exp 1 00000040", arvalid, araddr);
        end
        rvalid = 1; rdata = 32'hAB123456; rresp = 0; bus.smTaken = 1;
        #1;
        tests++;
        if (bus.smValid !== 1'b1 || bus.smID !== 8'h2A || bus.smData !== 24'h123456 || rready !== 1'b1) begin
            failed++; $display("FAIL read_resp: smValid %b smID %h smData %h rready %b exp 1 2a 123456 1",
                               bus.smValid, bus.smID, bus.smData, rready);
        end
        step();
        rvalid = 0; bus.smTaken = 0;
        #1;
        tests++;
        if (arvalid !== 1'b0 || bus.smValid !== 1'b0) begin
            failed++; $display("FAIL read_idle: arvalid %b smValid %b exp 0 0", arvalid, bus.smValid);
        end
    endtask

    task automatic test_read_fifo();
        arready = 1;
        bus.msWrite = 0;
        for (int i = 1; i <= 4; i++) begin
            bus.msValid = 1; bus.msID = 8'(i); bus.msAddress = 30'(i);
            #1;
            tests++;
            if (bus.msTaken !== 1'b1) begin failed++; $display("FAIL fifo_fill%0d: got %b exp 1", i, bus.msTaken); end
            step();
        end
        bus.msID = 8'd5;
        #1;
        tests++;
        if (bus.msTaken !== 1'b0) begin failed++; $display("FAIL fifo_full_refuse: got %b exp 0", bus.msTaken); end
        bus.msValid = 0;
        rvalid = 1; bus.smTaken = 1; rresp = 0;
        for (int i = 1; i <= 4; i++) begin
            rdata = 32'(i * 16);
            #1;
            tests++;
            if (bus.smValid !== 1'b1 || bus.smID !== 8'(i)) begin
                failed++; $display("FAIL fifo_order%0d: smValid %b smID %h exp 1 %h", i, bus.smValid, bus.smID, 8'(i));
            end
            step();
        end
        rvalid = 0; bus.smTaken = 0;
        bus.msValid = 1; bus.msID = 8'd5;
        #1;
        tests++;
        if (bus.msTaken !== 1'b1) begin failed++; $display("FAIL fifo_fifth_accept: got %b exp 1", bus.msTaken); end
        step();
        for (int i = 6; i <= 8; i++) begin
            bus.msID = 8'(i);
            #1;
            tests++;
            if (bus.msTaken !== 1'b1) begin failed++; $display("FAIL fifo_refill%0d: got %b exp 1", i, bus.msTaken); end
            step();
        end
        // Full FIFO: a push and a pop in the same cycle must both go through.
        bus.msID = 8'd9; rvalid = 1; bus.smTaken = 1;
        #1;
        tests++;
        if (bus.msTaken !== 1'b1 || bus.smID !== 8'd5) begin
            failed++; $display("FAIL fifo_push_pop: msTaken %b smID %h exp 1 05", bus.msTaken, bus.smID);
        end
        step();
        bus.msValid = 0;
        for (int i = 6; i <= 9; i++) begin
            #1;
            tests++;
            if (bus.smValid !== 1'b1 || bus.smID !== 8'(i)) begin
                failed++; $display("FAIL fifo_drain%0d: smValid %b smID %h exp 1 %h", i, bus.smValid, bus.smID, 8'(i));
            end
            step();
        end
        rvalid = 0; bus.smTaken = 0;
        #1;
        tests++;
        if (bus.smValid !== 1'b0) begin failed++; $display("FAIL fifo_empty_after: smValid %b exp 0", bus.smValid); end
    endtask

    task automatic test_write_aw_stall();
        awready = 0; wready = 1; bvalid = 0;
        bus.msValid = 1; bus.msWrite = 1; bus.msAddress = 30'h3; bus.msData = 24'hC0FFEE;
        #1;
        tests++;
        if (bus.msTaken !== 1'b1) begin failed++; $display("FAIL wr_accept: got %b exp 1", bus.msTaken); end
        step();
        bus.msValid = 0;
        tests++;
        if (awvalid !== 1'b1 || wvalid !== 1'b1 || awaddr !== 32'hC || wdata !== 32'h00C0FFEE || wstrb !== 4'hF) begin
            failed++; $display("FAIL wr_channels: aw %b w %b awaddr %h wdata %h wstrb %h exp 1 1 0000000c 00c0ffee f",
                               awvalid, wvalid, awaddr, wdata, wstrb);
        end
        for (int k = 1; k <= 3; k++) begin
            step();
            tests++;
            if (awvalid !== 1'b1 || wvalid !== 1'b0) begin
                failed++; $display("FAIL wr_aw_hold%0d: aw %b w %b exp 1 0", k, awvalid, wvalid);
            end
        end
        awready = 1;
        step();
        tests++;
        if (awvalid !== 1'b0) begin failed++; $display("FAIL wr_aw_drop: aw %b exp 0", awvalid); end
        bvalid = 1; bresp = 0;
        step();
        bvalid = 0;
    endtask

    task automatic test_write_limit();
        awready = 1; wready = 1; bvalid = 0;
        bus.msWrite = 1;
        for (int i = 0; i < 4; i++) begin
            bus.msValid = 1; bus.msAddress = 30'(i); bus.msData = 24'(i);
            #1;
            tests++;
            if (bus.msTaken !== 1'b1) begin failed++; $display("FAIL wlim_accept%0d: got %b exp 1", i, bus.msTaken); end
            step();
        end
        #1;
        tests++;
        if (bus.msTaken !== 1'b0) begin failed++; $display("FAIL wlim_refuse: got %b exp 0", bus.msTaken); end
        bvalid = 1; bresp = 0;
        #1;
        tests++;
        if (bus.msTaken !== 1'b1) begin failed++; $display("FAIL wlim_bvalid_accept: got %b exp 1", bus.msTaken); end
        step();
        bvalid = 0;
        #1;
        tests++;
        if (bus.msTaken !== 1'b0) begin failed++; $display("FAIL wlim_count_held: got %b exp 0", bus.msTaken); end
        bus.msValid = 0;
        for (int i = 0; i < 4; i++) begin
            bvalid = 1;
            step();
        end
        bvalid = 0;
    endtask

    task automatic test_errors();
        logic [15:0] exp_rd, exp_wr;
        awready = 1; wready = 1; arready = 1;
        for (int i = 0; i < 2; i++) begin
            bus.msValid = 1; bus.msWrite = 0; bus.msID = 8'h11; bus.msAddress = 30'h20;
            step();
            bus.msValid = 0;
            rvalid = 1; rresp = 2'b10; bus.smTaken = 1;
            step();
            rvalid = 0; rresp = 0; bus.smTaken = 0;
        end
        bus.msValid = 1; bus.msWrite = 1; bus.msAddress = 30'h21; bus.msData = 24'h55;
        step();
        bus.msValid = 0;
        step();
        bvalid = 1; bresp = 2'b11;
        step();
        bvalid = 0; bresp = 0;
`ifdef AXIL_ERR_COUNT_EN
        exp_rd = 16'd2; exp_wr = 16'd1;
`else
        exp_rd = 16'd0; exp_wr = 16'd0;
`endif
        tests++;
        if (rd_err_count !== exp_rd) begin failed++; $display("FAIL rd_err_count: got %0d exp %0d", rd_err_count, exp_rd); end
        tests++;
        if (wr_err_count !== exp_wr) begin failed++; $display("FAIL wr_err_count: got %0d exp %0d", wr_err_count, exp_wr); end
    endtask

    task automatic test_reset_midflight();
        arready = 1; bus.msWrite = 0;
        bus.msValid = 1; bus.msID = 8'hA1; step();
        bus.msID = 8'hA2; step();
        awready = 0; wready = 0;
        bus.msWrite = 1; bus.msAddress = 30'h7; bus.msData = 24'h7;
        step();
        bus.msValid = 0;
        reset = 1;
        step();
        reset = 0;
        tests++;
        if ({arvalid, awvalid, wvalid, bus.smValid} !== 4'b0000 || rd_err_count !== 16'h0) begin
            failed++; $display("FAIL rst_mid_valids: got %b errs %h exp 0000 0", {arvalid, awvalid, wvalid, bus.smValid}, rd_err_count);
        end
        bus.msValid = 1; bus.msWrite = 0; bus.msID = 8'h77;
        step();
        bus.msValid = 0;
        rvalid = 1; bus.smTaken = 1;
        #1;
        tests++;
        if (bus.smValid !== 1'b1 || bus.smID !== 8'h77) begin
            failed++; $display("FAIL rst_mid_id: smValid %b smID %h exp 1 77", bus.smValid, bus.smID);
        end
        step();
        rvalid = 0; bus.smTaken = 0;
        awready = 1; wready = 1; bus.msWrite = 1;
        for (int i = 0; i < 4; i++) begin
            bus.msValid = 1;
            #1;
            tests++;
            if (bus.msTaken !== 1'b1) begin failed++; $display("FAIL rst_mid_wr%0d: got %b exp 1", i, bus.msTaken); end
            step();
        end
        #1;
        tests++;
        if (bus.msTaken !== 1'b0) begin failed++; $display("FAIL rst_mid_wr_limit: got %b exp 0", bus.msTaken); end
        bus.msValid = 0;
        for (int i = 0; i < 4; i++) begin
            bvalid = 1;
            step();
        end
        bvalid = 0;
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_read_fifo();
        test_write_aw_stall();
        test_write_limit();
        test_errors();
        test_reset_midflight();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
